// File: rtl/control_sequencer.sv
// Microstep controller for the 8-bit SAP-2 datapath: fetch, decode and execute
// sequencing with combinational strobe decode from state, latched opcode and flag_zero.
module control_sequencer #(
  parameter int OPCODE_WIDTH = 4,
  parameter int STEP_WIDTH   = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    flag_zero,
  output logic                    pc_out_en,
  output logic                    pc_inc,
  output logic                    pc_load,
  output logic                    mar_load,
  output logic                    ram_out_en,
  output logic                    ram_we,
  output logic                    ir_load,
  output logic                    a_load,
  output logic                    a_out_en,
  output logic                    b_load,
  output logic                    alu_out_en,
  output logic                    alu_sub,
  output logic                    flags_load,
  output logic                    out_load,
  output logic                    instr_done,
  output logic                    halt,
  output logic                    illegal,
  output logic [STEP_WIDTH-1:0]   step
);

  localparam logic [OPCODE_WIDTH-1:0] OP_NOP = OPCODE_WIDTH'(4'h0);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDA = OPCODE_WIDTH'(4'h1);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDB = OPCODE_WIDTH'(4'h2);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(4'h3);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB = OPCODE_WIDTH'(4'h4);
  localparam logic [OPCODE_WIDTH-1:0] OP_STA = OPCODE_WIDTH'(4'h5);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDI = OPCODE_WIDTH'(4'h6);
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP = OPCODE_WIDTH'(4'h7);
  localparam logic [OPCODE_WIDTH-1:0] OP_JZ  = OPCODE_WIDTH'(4'h8);
  localparam logic [OPCODE_WIDTH-1:0] OP_OUT = OPCODE_WIDTH'(4'h9);
  localparam logic [OPCODE_WIDTH-1:0] OP_HLT = OPCODE_WIDTH'(4'hF);

  typedef enum logic [2:0] {
    S_T0, S_T1, S_T2, S_M0, S_M1, S_EX, S_HALT
  } state_t;

  state_t                  state;
  logic [OPCODE_WIDTH-1:0] op_q;
  logic [OPCODE_WIDTH-1:0] op_cur;
  logic                    is_mem2;
  logic                    is_mem1;
  logic                    is_alu;

  // During DECODE the latch is not yet loaded, so classify the live opcode.
  assign op_cur = (state == S_T2) ? opcode : op_q;

  always_comb begin
    is_mem2 = (op_cur == OP_LDA) || (op_cur == OP_LDB) || (op_cur == OP_STA);
    is_mem1 = (op_cur == OP_LDI) || (op_cur == OP_JMP) || (op_cur == OP_JZ);
    is_alu  = (op_cur == OP_ADD) || (op_cur == OP_SUB) || (op_cur == OP_OUT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_T0;
      op_q  <= '0;
    end else begin
      case (state)
        S_T0: state <= S_T1;
        S_T1: state <= S_T2;
        S_T2: begin
          op_q <= opcode;
          if (opcode == OP_NOP)          state <= S_T0;
          else if (is_mem2 || is_mem1)   state <= S_M0;
          else if (is_alu)               state <= S_EX;
          else                           state <= S_HALT;
        end
        S_M0:    state <= is_mem2 ? S_M1 : S_EX;
        S_M1:    state <= S_EX;
        S_EX:    state <= S_T0;
        default: state <= S_HALT;
      endcase
    end
  end

  always_comb begin
    pc_out_en  = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    mar_load   = 1'b0;
    ram_out_en = 1'b0;
    ram_we     = 1'b0;
    ir_load    = 1'b0;
    a_load     = 1'b0;
    a_out_en   = 1'b0;
    b_load     = 1'b0;
    alu_out_en = 1'b0;
    alu_sub    = 1'b0;
    flags_load = 1'b0;
    out_load   = 1'b0;
    instr_done = 1'b0;
    halt       = 1'b0;
    illegal    = 1'b0;
    step       = '0;
    // Reset masks every strobe so an aborted instruction never leaks a write.
    if (!reset) begin
      case (state)
        S_T0: begin
          pc_out_en = 1'b1;
          mar_load  = 1'b1;
          step      = STEP_WIDTH'(0);
        end
        S_T1: begin
          ram_out_en = 1'b1;
          ir_load    = 1'b1;
          pc_inc     = 1'b1;
          step       = STEP_WIDTH'(1);
        end
        S_T2: begin
          instr_done = (opcode == OP_NOP) || (opcode == OP_HLT);
          step       = STEP_WIDTH'(2);
        end
        S_M0: begin
          pc_out_en = 1'b1;
          mar_load  = 1'b1;
          step      = STEP_WIDTH'(3);
        end
        S_M1: begin
          ram_out_en = 1'b1;
          mar_load   = 1'b1;
          pc_inc     = 1'b1;
          step       = STEP_WIDTH'(4);
        end
        S_EX: begin
          instr_done = 1'b1;
          step = is_mem2 ? STEP_WIDTH'(5) : (is_mem1 ? STEP_WIDTH'(4) : STEP_WIDTH'(3));
          case (op_q)
            OP_LDA: begin ram_out_en = 1'b1; a_load = 1'b1; end
            OP_LDB: begin ram_out_en = 1'b1; b_load = 1'b1; end
            OP_ADD: begin alu_out_en = 1'b1; a_load = 1'b1; flags_load = 1'b1; end
            OP_SUB: begin
              alu_out_en = 1'b1; alu_sub = 1'b1; a_load = 1'b1; flags_load = 1'b1;
            end
            OP_STA: begin a_out_en = 1'b1; ram_we = 1'b1; end
            OP_LDI: begin ram_out_en = 1'b1; a_load = 1'b1; pc_inc = 1'b1; end
            OP_JMP: begin ram_out_en = 1'b1; pc_load = 1'b1; end
            OP_JZ: begin
              ram_out_en = flag_zero;
              pc_load    = flag_zero;
              pc_inc     = !flag_zero;
            end
            OP_OUT:  begin a_out_en = 1'b1; out_load = 1'b1; end
            default: ;
          endcase
        end
        default: begin
          halt    = 1'b1;
          illegal = (op_q != OP_HLT);
          step    = STEP_WIDTH'(3);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a table of per-cycle input/expected-output records,
// expected values queued as each vector is driven and popped when outputs are sampled.
module tb_control_sequencer;

  logic       clk;
  logic       reset;
  logic [3:0] opcode;
  logic       flag_zero;
  logic pc_out_en, pc_inc, pc_load, mar_load, ram_out_en, ram_we, ir_load;
  logic a_load, a_out_en, b_load, alu_out_en, alu_sub, flags_load, out_load;
  logic instr_done, halt, illegal;
  logic [2:0] step;

  control_sequencer #(.OPCODE_WIDTH(4), .STEP_WIDTH(3)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .flag_zero(flag_zero),
    .pc_out_en(pc_out_en), .pc_inc(pc_inc), .pc_load(pc_load), .mar_load(mar_load),
    .ram_out_en(ram_out_en), .ram_we(ram_we), .ir_load(ir_load),
    .a_load(a_load), .a_out_en(a_out_en), .b_load(b_load),
    .alu_out_en(alu_out_en), .alu_sub(alu_sub), .flags_load(flags_load),
    .out_load(out_load), .instr_done(instr_done), .halt(halt), .illegal(illegal),
    .step(step)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [16:0] PC_OE   = 17'd1 << 16;
  localparam logic [16:0] PC_INC  = 17'd1 << 15;
  localparam logic [16:0] PC_LD   = 17'd1 << 14;
  localparam logic [16:0] MAR     = 17'd1 << 13;
  localparam logic [16:0] RAM_OE  = 17'd1 << 12;
  localparam logic [16:0] RAM_WE  = 17'd1 << 11;
  localparam logic [16:0] IR_LD   = 17'd1 << 10;
  localparam logic [16:0] A_LD    = 17'd1 << 9;
  localparam logic [16:0] A_OE    = 17'd1 << 8;
  localparam logic [16:0] B_LD    = 17'd1 << 7;
  localparam logic [16:0] ALU_OE  = 17'd1 << 6;
  localparam logic [16:0] ALU_SUB = 17'd1 << 5;
  localparam logic [16:0] FLAGS   = 17'd1 << 4;
  localparam logic [16:0] OUT_LD  = 17'd1 << 3;
  localparam logic [16:0] DONE    = 17'd1 << 2;
  localparam logic [16:0] HALT    = 17'd1 << 1;
  localparam logic [16:0] ILL     = 17'd1 << 0;
  localparam logic [16:0] NONE    = 17'd0;

  typedef struct {
    logic        rst;
    logic [3:0]  op;
    logic        fz;
    logic [16:0] str;
    logic [2:0]  st;
  } vec_t;

  vec_t        vecs[$];
  logic [19:0] exp_q[$];
  int          n_cmp;
  int          n_bad;

  function automatic logic [3:0] rnd_op();
    return 4'($urandom_range(0, 15));
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic add(input logic r, input logic [3:0] op, input logic fz,
                     input logic [16:0] s, input logic [2:0] st);
    vec_t v;
    v.rst = r; v.op = op; v.fz = fz; v.str = s; v.st = st;
    vecs.push_back(v);
  endtask

  // T0, T1 and a silent DECODE cycle presenting op
  task automatic add_fetch(input logic [3:0] op);
    add(1'b0, rnd_op(), rnd_bit(), PC_OE | MAR, 3'd0);
    add(1'b0, rnd_op(), rnd_bit(), RAM_OE | IR_LD | PC_INC, 3'd1);
    add(1'b0, op, rnd_bit(), NONE, 3'd2);
  endtask

  task automatic add_operand(input logic two);
    add(1'b0, rnd_op(), rnd_bit(), PC_OE | MAR, 3'd3);
    if (two) add(1'b0, rnd_op(), rnd_bit(), RAM_OE | MAR | PC_INC, 3'd4);
  endtask

  function automatic logic [19:0] sample();
    return {pc_out_en, pc_inc, pc_load, mar_load, ram_out_en, ram_we, ir_load,
            a_load, a_out_en, b_load, alu_out_en, alu_sub, flags_load, out_load,
            instr_done, halt, illegal, step};
  endfunction

  // driver: apply one vector on the falling edge, check outputs mid-low-phase
  task automatic apply(input vec_t v, input int idx);
    logic [19:0] got;
    logic [19:0] want;
    int          busy;
    @(negedge clk);
    reset     = v.rst;
    opcode    = v.op;
    flag_zero = v.fz;
    exp_q.push_back({v.str, v.st});
    #2;
    got  = sample();
    want = exp_q.pop_front();
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL outputs cyc=%0d got=%05h want=%05h", idx, got, want);
    end
    busy = int'(pc_out_en) + int'(ram_out_en) + int'(a_out_en) + int'(alu_out_en);
    n_cmp++;
    if (busy > 1) begin
      n_bad++;
      $display("FAIL bus_excl cyc=%0d drivers=%0d want<=1", idx, busy);
    end
    n_cmp++;
    if (ram_we && ram_out_en) begin
      n_bad++;
      $display("FAIL we_vs_oe cyc=%0d ram_we=%b ram_out_en=%b want not both", idx, ram_we, ram_out_en);
    end
    n_cmp++;
    if (alu_sub && !alu_out_en) begin
      n_bad++;
      $display("FAIL sub_wo_alu cyc=%0d alu_sub=%b alu_out_en=%b", idx, alu_sub, alu_out_en);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    opcode = 4'h2;
    flag_zero = 1'b0;

    // reset held 3 cycles with opcode 0x2
    for (int i = 0; i < 3; i++) add(1'b1, 4'h2, rnd_bit(), NONE, 3'd0);
    // LDB
    add_fetch(4'h2); add_operand(1'b1);
    add(1'b0, rnd_op(), rnd_bit(), RAM_OE | B_LD | DONE, 3'd5);
    // SUB then ADD back to back
    add_fetch(4'h4);
    add(1'b0, 4'h3, rnd_bit(), ALU_OE | ALU_SUB | A_LD | FLAGS | DONE, 3'd3);
    add_fetch(4'h3);
    add(1'b0, 4'h4, rnd_bit(), ALU_OE | A_LD | FLAGS | DONE, 3'd3);
    // JZ taken, flag only low before the execute cycle
    add_fetch(4'h8);
    add(1'b0, rnd_op(), 1'b0, PC_OE | MAR, 3'd3);
    add(1'b0, rnd_op(), 1'b1, RAM_OE | PC_LD | DONE, 3'd4);
    // JZ not taken
    add_fetch(4'h8);
    add(1'b0, rnd_op(), 1'b1, PC_OE | MAR, 3'd3);
    add(1'b0, rnd_op(), 1'b0, PC_INC | DONE, 3'd4);
    // LDA, STA, LDI, JMP, OUT
    add_fetch(4'h1); add_operand(1'b1);
    add(1'b0, rnd_op(), rnd_bit(), RAM_OE | A_LD | DONE, 3'd5);
    add_fetch(4'h5); add_operand(1'b1);
    add(1'b0, rnd_op(), rnd_bit(), A_OE | RAM_WE | DONE, 3'd5);
    add_fetch(4'h6); add_operand(1'b0);
    add(1'b0, rnd_op(), rnd_bit(), RAM_OE | A_LD | PC_INC | DONE, 3'd4);
    add_fetch(4'h7); add_operand(1'b0);
    add(1'b0, rnd_op(), rnd_bit(), RAM_OE | PC_LD | DONE, 3'd4);
    add_fetch(4'h9);
    add(1'b0, rnd_op(), rnd_bit(), A_OE | OUT_LD | DONE, 3'd3);
    // STA aborted by reset in M1, then a NOP
    add_fetch(4'h5); add_operand(1'b0);
    add(1'b1, rnd_op(), rnd_bit(), NONE, 3'd0);
    add(1'b0, rnd_op(), rnd_bit(), PC_OE | MAR, 3'd0);
    add(1'b0, rnd_op(), rnd_bit(), RAM_OE | IR_LD | PC_INC, 3'd1);
    add(1'b0, 4'h0, rnd_bit(), DONE, 3'd2);
    // HLT held 20 cycles, then reset
    add_fetch(4'h3);
    add(1'b0, 4'h3, rnd_bit(), ALU_OE | A_LD | FLAGS | DONE, 3'd3);
    add(1'b0, rnd_op(), rnd_bit(), PC_OE | MAR, 3'd0);
    add(1'b0, rnd_op(), rnd_bit(), RAM_OE | IR_LD | PC_INC, 3'd1);
    add(1'b0, 4'hF, rnd_bit(), DONE, 3'd2);
    for (int i = 0; i < 20; i++) add(1'b0, rnd_op(), rnd_bit(), HALT, 3'd3);
    add(1'b1, rnd_op(), rnd_bit(), NONE, 3'd0);
    // illegal opcode 0xB
    add_fetch(4'hB);
    for (int i = 0; i < 5; i++) add(1'b0, rnd_op(), rnd_bit(), HALT | ILL, 3'd3);
    add(1'b1, rnd_op(), rnd_bit(), NONE, 3'd0);
    add(1'b0, rnd_op(), rnd_bit(), PC_OE | MAR, 3'd0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL exp_q_drain left=%0d want=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Microstep controller for the 8-bit SAP-2 datapath.
- Sequences fetch, decode and execute for each instruction.
- Drives every load, enable and write strobe on the shared bus: PC, MAR, RAM, IR, A, B, ALU, flags, OUT.
- Sits between the instruction register and the datapath. Replaces ad-hoc per-instruction control.

Parameters:
- OPCODE_WIDTH, 4, width of opcode field (IR upper nibble).
- STEP_WIDTH, 3, width of debug microstep output.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- opcode  input  OPCODE_WIDTH  IR[7:4]; valid from the DECODE cycle onward.
- flag_zero  input  1  registered zero flag from flags register.
- pc_out_en, pc_inc, pc_load  output  1 each  program counter controls.
- mar_load  output  1  memory address register load.
- ram_out_en, ram_we  output  1 each  RAM drive bus / write.
- ir_load  output  1  instruction register load.
- a_load, a_out_en, b_load  output  1 each  register controls.
- alu_out_en, alu_sub, flags_load  output  1 each  ALU and flags controls.
- out_load  output  1  output register load.
- instr_done  output  1  pulse on final microstep of each instruction.
- halt  output  1  level, CPU halted.
- illegal  output  1  level, halted on undefined opcode.
- step  output  STEP_WIDTH  current microstep index (debug).

Behaviour:
- Reset cycle (reset=1): all outputs forced 0, including ram_we.
  - Next state is T0, op latch cleared, halt/illegal cleared.
  - Reset mid-instruction aborts it; no partial strobes are issued.
- Outputs are combinational decode of state, latched opcode and flag_zero. No output is registered.
- Common fetch (all instructions):
  - T0: pc_out_en, mar_load.
  - T1: ram_out_en, ir_load, pc_inc.
  - T2 (DECODE): no strobes; latch opcode internally; branch.
- Operand fetch, for memory-operand ops:
  - M0: pc_out_en, mar_load.
  - M1: ram_out_en, mar_load, pc_inc.
- Opcodes and their microsteps after T2:
  - 0x0 NOP: instr_done in T2. 3 cycles.
  - 0x1 LDA: M0, M1, E = ram_out_en+a_load. 6 cycles.
  - 0x2 LDB: M0, M1, E = ram_out_en+b_load. 6 cycles.
  - 0x3 ADD: E = alu_out_en+a_load+flags_load. 4 cycles.
  - 0x4 SUB: as ADD plus alu_sub. 4 cycles.
  - 0x5 STA: M0, M1, E = a_out_en+ram_we. 6 cycles.
  - 0x6 LDI: M0, then ram_out_en+a_load+pc_inc. 5 cycles.
  - 0x7 JMP: M0, then ram_out_en+pc_load. 5 cycles.
  - 0x8 JZ: M0, then either ram_out_en+pc_load (flag_zero=1) or pc_inc only (flag_zero=0). flag_zero is sampled in that cycle. 5 cycles either way.
  - 0x9 OUT: E = a_out_en+out_load. 4 cycles.
  - 0xF HLT: go to HALT.
  - 0xA-0xE: go to HALT with illegal=1.
- instr_done is asserted in the final microstep only. The next cycle is T0.
- HALT state:
  - halt=1 from the cycle after DECODE onward; all other strobes 0.
  - Held indefinitely; only reset exits.
  - instr_done is asserted once, in the DECODE cycle of HLT.
- Invariants, every cycle:
  - At most one of pc_out_en, ram_out_en, a_out_en, alu_out_en is 1.
  - ram_we is never 1 together with ram_out_en.
  - alu_sub only with alu_out_en.
- step reports the cycle index within the instruction: 0 for T0, up to 5. Holds 3 in HALT.
- opcode changes after DECODE have no effect, because the latched value is used.

Test Plan:
- Reset: hold reset 3 cycles with opcode=0x2 -> all outputs 0 throughout. First cycle after release: pc_out_en=mar_load=1, step=0.
- LDB (opcode 0x2) -> 6-cycle trace matches table exactly. b_load=1 only in cycle 6, together with ram_out_en and instr_done. Next cycle is T0.
- SUB (0x4) then ADD (0x3) back to back -> cycle 4: alu_out_en, alu_sub, a_load, flags_load=1 for SUB; alu_sub=0 for ADD. Total 8 cycles.
- JZ (0x8) two cases:
  - flag_zero=1 -> cycle 5: ram_out_en+pc_load.
  - flag_zero=0 -> cycle 5: pc_inc only, ram_out_en=0, pc_load=0.
- HLT (0xF) -> halt=1 from cycle 4, stays 1 for 20 cycles with all strobes 0. Opcode 0xB -> halt=illegal=1. Reset clears both.
- Reset asserted during M1 of STA (0x5) -> ram_we never asserted. Sequencer restarts at T0; a following NOP completes in 3 cycles.
- Throughout all runs, check the bus-exclusivity invariants every cycle.
